// File: rtl/vs_memory_pkg.sv
// Shared types and helpers for the memory library.
//   rdw_mode_t        : same-address read-during-write policy
//   ram_clear_state_t : post-reset clear sequencer states
//   lane_count()      : number of byte-enable lanes in a word
package vs_memory_pkg;

  typedef enum logic {
    READ_FIRST  = 1'b0,
    WRITE_FIRST = 1'b1
  } rdw_mode_t;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_clear_state_t;

  function automatic int lane_count(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/vs_ram_clear_sequencer.sv
// Post-reset clear sequencer: after reset it walks every address from 0 to
// DEPTH-1, one per cycle, requesting an all-lanes zero write, then parks in
// READY until the next reset.
// Ports:
//   clock       in   sole clock
//   reset_n     in   synchronous active-low reset; restarts the sweep at 0
//   init_busy   out  high while the sweep is running
//   clear_write out  zero-write request for this cycle
//   clear_addr  out  address of the zero write
module vs_ram_clear_sequencer
  import vs_memory_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DEPTH          = 2**ADDR_WIDTH,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic                  init_busy,
  output logic                  clear_write,
  output logic [ADDR_WIDTH-1:0] clear_addr
);

  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] ONE       = (ADDR_WIDTH+1)'(1);

  ram_clear_state_t      state;
  // One bit wider than the address so DEPTH == 2**ADDR_WIDTH cannot wrap.
  logic [ADDR_WIDTH:0]   count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
      if (CLEAR_ON_RESET != 0) begin
        state     <= CLEAR;
        init_busy <= 1'b1;
      end else begin
        state     <= READY;
        init_busy <= 1'b0;
      end
    end else begin
      case (state)
        CLEAR: begin
          count <= count + ONE;
          // busy drops on the same edge that writes the last address
          if (count == LAST_ADDR) begin
            state     <= READY;
            init_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign clear_write = (state == CLEAR);
  assign clear_addr  = count[ADDR_WIDTH-1:0];

endmodule

// File: rtl/vs_sdp_sync_ram.sv
// Simple dual-port single-clock synchronous RAM with byte-lane writes,
// read-valid strobe, optional output register, selectable read-during-write
// policy and an optional post-reset zero-fill.
// Ports:
//   clock, reset_n          clock and synchronous active-low reset
//   write_enable/addr/byte_en/in_data   write port (lane-masked)
//   read_enable/read_addr   read request
//   out_data/out_valid      read result, 1 + OUTPUT_REG cycles after request
//   init_busy               zero-fill in progress; requests ignored
module vs_sdp_sync_ram
  import vs_memory_pkg::*;
#(
  parameter int        DATA_WIDTH     = 8,
  parameter int        BYTE_WIDTH     = 8,
  parameter int        ADDR_WIDTH     = 16,
  parameter int        DEPTH          = 2**ADDR_WIDTH,
  parameter int        OUTPUT_REG     = 0,
  parameter rdw_mode_t RDW_MODE       = READ_FIRST,
  parameter int        CLEAR_ON_RESET = 1
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             write_enable,
  input  logic [ADDR_WIDTH-1:0]            write_addr,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] write_byte_en,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic                             read_enable,
  input  logic [ADDR_WIDTH-1:0]            read_addr,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  output logic                             init_busy
);

  localparam int                  LANES   = lane_count(DATA_WIDTH, BYTE_WIDTH);
  localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH+1)'(DEPTH);

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_lane_width
    $error("vs_sdp_sync_ram: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("vs_sdp_sync_ram: DEPTH exceeds the address space");
  end

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [LANES-1:0]      lane_en
  );
    logic [DATA_WIDTH-1:0] w;
    w = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (lane_en[i]) w[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return w;
  endfunction

  logic                  clear_write;
  logic [ADDR_WIDTH-1:0] clear_addr;

  vs_ram_clear_sequencer #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear (
    .clock       (clock),
    .reset_n     (reset_n),
    .init_busy   (init_busy),
    .clear_write (clear_write),
    .clear_addr  (clear_addr)
  );

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic wr_in_range, rd_in_range, wr_fire, rd_fire;
  assign wr_in_range = ({1'b0, write_addr} < DEPTH_X);
  assign rd_in_range = ({1'b0, read_addr} < DEPTH_X);
  assign wr_fire     = write_enable && !init_busy && wr_in_range;
  assign rd_fire     = read_enable && !init_busy;

  // Array write port: the clear sequencer owns it while sweeping.
  logic                  arr_we;
  logic [IDX_W-1:0]      arr_idx;
  logic [DATA_WIDTH-1:0] arr_data;
  logic [LANES-1:0]      arr_lane_en;

  always_comb begin
    arr_we      = wr_fire;
    arr_idx     = write_addr[IDX_W-1:0];
    arr_data    = in_data;
    arr_lane_en = write_byte_en;
    if (clear_write) begin
      arr_we      = 1'b1;
      arr_idx     = clear_addr[IDX_W-1:0];
      arr_data    = '0;
      arr_lane_en = '1;
    end
  end

  always_ff @(posedge clock) begin
    if (arr_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (arr_lane_en[i]) mem[arr_idx][i*BYTE_WIDTH +: BYTE_WIDTH] <= arr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Out-of-range reads return zero; WRITE_FIRST forwards the merged word
  // when an accepted write hits the same address in the same cycle.
  logic [DATA_WIDTH-1:0] rd_word;
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[read_addr[IDX_W-1:0]];
      if (RDW_MODE == WRITE_FIRST && wr_fire && (write_addr == read_addr))
        rd_word = merge_lanes(rd_word, in_data, write_byte_en);
    end
  end

  // ---- stage p0: array read capture ----
  logic                  vld_p0;
  logic [DATA_WIDTH-1:0] data_p0;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= rd_fire;
      if (rd_fire) data_p0 <= rd_word;
    end
  end

  // ---- stage p1: optional output register ----
  if (OUTPUT_REG != 0) begin : g_out_reg
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        vld_p1  <= 1'b0;
        data_p1 <= '0;
      end else begin
        vld_p1 <= vld_p0;
        if (vld_p0) data_p1 <= data_p0;
      end
    end

    assign out_data  = data_p1;
    assign out_valid = vld_p1;
  end else begin : g_no_out_reg
    assign out_data  = data_p0;
    assign out_valid = vld_p0;
  end

endmodule

// File: tb/tb_vs_sdp_sync_ram.sv
// Directed bench for vs_sdp_sync_ram. Three instances share one stimulus:
//   a : DEPTH=16, latency 1, READ_FIRST
//   b : DEPTH=16, latency 2, WRITE_FIRST
//   c : DEPTH=12, latency 1, READ_FIRST (out-of-range coverage)
module tb_vs_sdp_sync_ram;
  import vs_memory_pkg::*;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        we, re;
  logic [3:0]  wa, ra;
  logic [1:0]  wbe;
  logic [15:0] wd;

  logic [15:0] od_a, od_b, od_c;
  logic        ov_a, ov_b, ov_c;
  logic        ib_a, ib_b, ib_c;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  vs_sdp_sync_ram #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16),
                    .OUTPUT_REG(0), .RDW_MODE(READ_FIRST), .CLEAR_ON_RESET(1)) u_a (
    .clock(clock), .reset_n(rst_n), .write_enable(we), .write_addr(wa),
    .write_byte_en(wbe), .in_data(wd), .read_enable(re), .read_addr(ra),
    .out_data(od_a), .out_valid(ov_a), .init_busy(ib_a));

  vs_sdp_sync_ram #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16),
                    .OUTPUT_REG(1), .RDW_MODE(WRITE_FIRST), .CLEAR_ON_RESET(1)) u_b (
    .clock(clock), .reset_n(rst_n), .write_enable(we), .write_addr(wa),
    .write_byte_en(wbe), .in_data(wd), .read_enable(re), .read_addr(ra),
    .out_data(od_b), .out_valid(ov_b), .init_busy(ib_b));

  vs_sdp_sync_ram #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12),
                    .OUTPUT_REG(0), .RDW_MODE(READ_FIRST), .CLEAR_ON_RESET(1)) u_c (
    .clock(clock), .reset_n(rst_n), .write_enable(we), .write_addr(wa),
    .write_byte_en(wbe), .in_data(wd), .read_enable(re), .read_addr(ra),
    .out_data(od_c), .out_valid(ov_c), .init_busy(ib_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    we = 1'b1; wa = a; wd = d; wbe = be;
    tick();
    we = 1'b0;
  endtask

  // Single read; a/c answer after one edge, b after two.
  task automatic read_one(input string tag, input logic [3:0] a,
                          input logic [15:0] ea, input logic [15:0] eb, input logic [15:0] ec);
    re = 1'b1; ra = a;
    tick();
    re = 1'b0;
    chk({tag, "_a"}, od_a, ea);  chk({tag, "_va"}, ov_a, 1);
    chk({tag, "_c"}, od_c, ec);  chk({tag, "_vc"}, ov_c, 1);
    tick();
    chk({tag, "_b"}, od_b, eb);  chk({tag, "_vb"}, ov_b, 1);
  endtask

  // Back-to-back reads of addresses 0..n-1; expected word is i*mult,
  // and zero in c beyond its 12 words.
  task automatic read_stream(input string tag, input int n, input logic [15:0] mult);
    logic [15:0] ea, ec, eb;
    for (int i = 0; i <= n; i++) begin
      re = (i < n); ra = 4'(i);
      tick();
      ea = 16'(i) * mult;
      ec = (i < 12) ? ea : 16'h0000;
      eb = 16'(i - 1) * mult;
      if (i < n) begin
        chk($sformatf("%s_a%0d", tag, i), od_a, ea);  chk($sformatf("%s_va%0d", tag, i), ov_a, 1);
        chk($sformatf("%s_c%0d", tag, i), od_c, ec);  chk($sformatf("%s_vc%0d", tag, i), ov_c, 1);
      end else begin
        chk($sformatf("%s_idle_va", tag), ov_a, 0);
        chk($sformatf("%s_hold_a", tag), od_a, 16'(n - 1) * mult);
      end
      if (i > 0) begin
        chk($sformatf("%s_b%0d", tag, i - 1), od_b, eb);  chk($sformatf("%s_vb%0d", tag, i - 1), ov_b, 1);
      end
    end
    re = 1'b0;
  endtask

  // Counts init_busy cycles from the last reset edge; also issues a write and
  // a read of address 2 mid-sweep, both of which must be ignored.
  task automatic count_clear(input string tag, input int ea, input int eb, input int ec);
    int ca = 0, cb = 0, cc = 0;
    bit sawv = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (ib_a) ca++;
      if (ib_b) cb++;
      if (ib_c) cc++;
      if (ov_a || ov_b || ov_c) sawv = 1'b1;
      if (i == 3) begin
        we = 1'b1; wa = 4'd2; wd = 16'hFFFF; wbe = 2'b11; re = 1'b1; ra = 4'd2;
      end else begin
        we = 1'b0; re = 1'b0;
      end
      tick();
    end
    chk({tag, "_busy_a"}, ca, ea);
    chk({tag, "_busy_b"}, cb, eb);
    chk({tag, "_busy_c"}, cc, ec);
    chk({tag, "_no_valid"}, sawv, 0);
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; re = 1'b0; wa = '0; ra = '0; wbe = '0; wd = '0;

    // reset held for two edges
    tick();
    tick();
    chk("rst_ov_a", ov_a, 0);  chk("rst_od_a", od_a, 0);
    chk("rst_ov_b", ov_b, 0);  chk("rst_od_b", od_b, 0);
    chk("rst_busy_a", ib_a, 1); chk("rst_busy_c", ib_c, 1);
    rst_n = 1'b1;
    count_clear("clr1", 16, 16, 12);

    // everything zero, including address 2 written during the clear
    read_stream("zero", 16, 16'h0000);

    // fill 0..9 then stream back
    for (int i = 0; i < 10; i++) wr(4'(i), 16'(i) * 16'h0101, 2'b11);
    read_stream("fill", 10, 16'h0101);

    // byte enables, including an all-zero mask
    wr(4'd3, 16'h1234, 2'b11);
    wr(4'd3, 16'hABCD, 2'b01);
    wr(4'd3, 16'hFFFF, 2'b00);
    read_one("be", 4'd3, 16'h12CD, 16'h12CD, 16'h12CD);

    // same-address read during write, full word, then the next-cycle read
    wr(4'd5, 16'h00AA, 2'b11);
    we = 1'b1; wa = 4'd5; wd = 16'h0055; wbe = 2'b11; re = 1'b1; ra = 4'd5;
    tick();
    we = 1'b0;
    chk("rdw_a", od_a, 16'h00AA);  chk("rdw_c", od_c, 16'h00AA);
    tick();
    re = 1'b0;
    chk("rdw_next_a", od_a, 16'h0055);  chk("rdw_next_c", od_c, 16'h0055);
    chk("rdw_b", od_b, 16'h0055);
    tick();
    chk("rdw_next_b", od_b, 16'h0055);  chk("rdw_next_vb", ov_b, 1);

    // same-address read during a partial write: upper lane only
    wr(4'd6, 16'h1122, 2'b11);
    we = 1'b1; wa = 4'd6; wd = 16'h3344; wbe = 2'b10; re = 1'b1; ra = 4'd6;
    tick();
    we = 1'b0; re = 1'b0;
    chk("rdwp_a", od_a, 16'h1122);  chk("rdwp_c", od_c, 16'h1122);
    tick();
    chk("rdwp_b", od_b, 16'h3322);
    read_one("rdwp_after", 4'd6, 16'h3322, 16'h3322, 16'h3322);

    // address 13 exists in a/b but not in c
    wr(4'd13, 16'hBEEF, 2'b11);
    read_one("oor13", 4'd13, 16'hBEEF, 16'hBEEF, 16'h0000);
    read_one("oor_alias1", 4'd1, 16'h0101, 16'h0101, 16'h0101);

    // reset again, then reset once more with the counter at 7
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (7) tick();
    chk("mid_busy_a", ib_a, 1);  chk("mid_busy_c", ib_c, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    count_clear("clr2", 16, 16, 12);
    read_one("clr2_rd9", 4'd9, 16'h0000, 16'h0000, 16'h0000);

    // two reads in flight through the latency-2 instance, then reset
    wr(4'd4, 16'h4444, 2'b11);
    re = 1'b1; ra = 4'd4;
    tick();
    tick();
    chk("flight_pre_vb", ov_b, 1);  chk("flight_pre_b", od_b, 16'h4444);
    rst_n = 1'b0; re = 1'b0;
    tick();
    chk("flight_vb", ov_b, 0);  chk("flight_b", od_b, 16'h0000);
    chk("flight_va", ov_a, 0);  chk("flight_a", od_a, 16'h0000);
    rst_n = 1'b1;
    tick();
    chk("flight_vb_next", ov_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
